bram_row_loader: RTL and testbench

BRAM_ROW_LOADER -- requirements
Module: bram_row_loader

---
 rtl/bram_row_loader.sv | 193 +++++++++++++++++++
 tb/tb_bram_row_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_row_loader.sv
`timescale 1ns/1ps
// Streams paired ref/search pixels into two row-ring BRAMs; each accepted beat is written one cycle later.
// Stalls the pixel stream while the ring holds NUM_OF_ROWS_IN_BRAM unconsumed rows or the frame is fully loaded.
module bram_row_loader #(
  parameter int NUM_OF_ROWS_IN_BRAM = 8,
  parameter int HRES                = 640,
  parameter int VRES                = 480,
  parameter int BRAM_DATA_WIDTH     = 16,
  parameter int BRAM_ADDR_WIDTH     = 13,
  parameter int BRAM_WE_WIDTH       = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       pix_valid,
  input  logic [BRAM_DATA_WIDTH-1:0] pix_ref,
  input  logic [BRAM_DATA_WIDTH-1:0] pix_search,
  output logic                       pix_ready,
  output logic                       en_ref,
  output logic [BRAM_WE_WIDTH-1:0]   we_ref,
  output logic [BRAM_ADDR_WIDTH-1:0] addr_ref,
  output logic [BRAM_DATA_WIDTH-1:0] din_ref,
  output logic                       en_search,
  output logic [BRAM_WE_WIDTH-1:0]   we_search,
  output logic [BRAM_ADDR_WIDTH-1:0] addr_search,
  output logic [BRAM_DATA_WIDTH-1:0] din_search,
  output logic                       busy_ref,
  output logic                       busy_search,
  output logic                       go,
  input  logic                       finished_row,
  output logic                       frame_done,
  output logic                       underflow_err
);

  localparam int ROW_W   = (NUM_OF_ROWS_IN_BRAM > 1) ? $clog2(NUM_OF_ROWS_IN_BRAM) : 1;
  localparam int COL_W   = (HRES > 1) ? $clog2(HRES) : 1;
  localparam int RES_W   = $clog2(NUM_OF_ROWS_IN_BRAM + 1);
  localparam int RL_W    = $clog2(VRES + 1);
  localparam int GO_ROWS = (NUM_OF_ROWS_IN_BRAM < VRES) ? NUM_OF_ROWS_IN_BRAM : VRES;

  localparam logic [COL_W-1:0]           COL_LAST  = COL_W'(HRES - 1);
  localparam logic [ROW_W-1:0]           ROW_LAST  = ROW_W'(NUM_OF_ROWS_IN_BRAM - 1);
  localparam logic [RES_W-1:0]           RES_FULL  = RES_W'(NUM_OF_ROWS_IN_BRAM);
  localparam logic [RES_W-1:0]           RES_GO    = RES_W'(GO_ROWS);
  localparam logic [RL_W-1:0]            RL_END    = RL_W'(VRES);
  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_HRES = BRAM_ADDR_WIDTH'(HRES);

  typedef enum logic [1:0] {IDLE, LOAD, FULL, DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [ROW_W-1:0]           wr_row_q, wr_row_d;
  logic [BRAM_ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [COL_W-1:0]           col_q, col_d;
  logic [RL_W-1:0]            rows_loaded_q, rows_loaded_d;
  logic [RES_W-1:0]           resident_q, resident_d;
  logic                       go_q, go_d;
  logic                       frame_done_q, frame_done_d;
  logic                       underflow_q, underflow_d;
  logic                       wr_q, wr_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BRAM_DATA_WIDTH-1:0] din_ref_q, din_ref_d;
  logic [BRAM_DATA_WIDTH-1:0] din_search_q, din_search_d;

  logic accept, row_done, fin_ok;

  assign pix_ready = (state_q == LOAD);
  assign accept    = pix_valid && pix_ready;
  assign row_done  = accept && (col_q == COL_LAST);
  // A finished_row with nothing resident is an upstream protocol error, not a consume.
  assign fin_ok    = finished_row && (resident_q != '0);

  always_comb begin
    state_d       = state_q;
    wr_row_d      = wr_row_q;
    row_base_d    = row_base_q;
    col_d         = col_q;
    rows_loaded_d = rows_loaded_q;
    resident_d    = resident_q;
    go_d          = go_q;
    frame_done_d  = 1'b0;
    underflow_d   = underflow_q | (finished_row && (resident_q == '0));
    wr_d          = 1'b0;
    addr_d        = addr_q;
    din_ref_d     = din_ref_q;
    din_search_d  = din_search_q;

    if (row_done && !fin_ok) begin
      resident_d = resident_q + RES_W'(1);
    end else if (!row_done && fin_ok) begin
      resident_d = resident_q - RES_W'(1);
    end

    if (accept) begin
      wr_d         = 1'b1;
      addr_d       = row_base_q + BRAM_ADDR_WIDTH'(col_q);
      din_ref_d    = pix_ref;
      din_search_d = pix_search;
      if (row_done) begin
        col_d         = '0;
        wr_row_d      = (wr_row_q == ROW_LAST) ? '0 : wr_row_q + ROW_W'(1);
        row_base_d    = (wr_row_q == ROW_LAST) ? '0 : row_base_q + ADDR_HRES;
        rows_loaded_d = rows_loaded_q + RL_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    if (state_q != IDLE && resident_q == RES_GO) begin
      go_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = LOAD;
          wr_row_d      = '0;
          row_base_d    = '0;
          col_d         = '0;
          rows_loaded_d = '0;
          resident_d    = '0;
          go_d          = 1'b0;
        end
      end
      LOAD: begin
        if (rows_loaded_d == RL_END) begin
          state_d = DRAIN;
        end else if (resident_d == RES_FULL) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (resident_d != RES_FULL) begin
          state_d = LOAD;
        end
      end
      DRAIN: begin
        if (resident_d == '0) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
          go_d         = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      wr_row_q      <= '0;
      row_base_q    <= '0;
      col_q         <= '0;
      rows_loaded_q <= '0;
      resident_q    <= '0;
      go_q          <= 1'b0;
      frame_done_q  <= 1'b0;
      underflow_q   <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      din_ref_q     <= '0;
      din_search_q  <= '0;
    end else begin
      state_q       <= state_d;
      wr_row_q      <= wr_row_d;
      row_base_q    <= row_base_d;
      col_q         <= col_d;
      rows_loaded_q <= rows_loaded_d;
      resident_q    <= resident_d;
      go_q          <= go_d;
      frame_done_q  <= frame_done_d;
      underflow_q   <= underflow_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      din_ref_q     <= din_ref_d;
      din_search_q  <= din_search_d;
    end
  end

  assign en_ref        = wr_q;
  assign en_search     = wr_q;
  assign we_ref        = {BRAM_WE_WIDTH{wr_q}};
  assign we_search     = {BRAM_WE_WIDTH{wr_q}};
  assign busy_ref      = wr_q;
  assign busy_search   = wr_q;
  assign addr_ref      = addr_q;
  assign addr_search   = addr_q;
  assign din_ref       = din_ref_q;
  assign din_search    = din_search_q;
  assign go            = go_q;
  assign frame_done    = frame_done_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_bram_row_loader.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for bram_row_loader against a row/beat counting reference model.
module tb_bram_row_loader;

  localparam int N  = 4;
  localparam int H  = 12;
  localparam int V  = 10;
  localparam int DW = 16;
  localparam int AW = 13;
  localparam int WW = 1;
  localparam int GO_ROWS = (N < V) ? N : V;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_ref = '0;
  logic [DW-1:0] pix_search = '0;
  logic          finished_row = 1'b0;
  logic          pix_ready, en_ref, en_search, busy_ref, busy_search, go, frame_done, underflow_err;
  logic [WW-1:0] we_ref, we_search;
  logic [AW-1:0] addr_ref, addr_search;
  logic [DW-1:0] din_ref, din_search;

  always #5 clk = ~clk;

  bram_row_loader #(
    .NUM_OF_ROWS_IN_BRAM(N), .HRES(H), .VRES(V),
    .BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .BRAM_WE_WIDTH(WW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
    .pix_ref(pix_ref), .pix_search(pix_search), .pix_ready(pix_ready),
    .en_ref(en_ref), .we_ref(we_ref), .addr_ref(addr_ref), .din_ref(din_ref),
    .en_search(en_search), .we_search(we_search), .addr_search(addr_search), .din_search(din_search),
    .busy_ref(busy_ref), .busy_search(busy_search), .go(go), .finished_row(finished_row),
    .frame_done(frame_done), .underflow_err(underflow_err)
  );

  int chk = 0;
  int err = 0;
  int cyc = 0;
  int wr_count = 0;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] r;
    logic [DW-1:0] s;
  } wr_t;
  wr_t q[$];

  // Reference model: frame in progress, beats accepted, rows resident.
  bit m_active = 0, m_go = 0, m_fd = 0, m_uf = 0;
  int m_beats = 0, m_res = 0, m_frames = 0;

  function automatic bit exp_ready();
    return m_active && (m_res < N) && ((m_beats / H) < V);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : model
    bit rdy, acc, done_row, fin_ok;
    int rows_pre;
    wr_t e;
    if (!reset) begin
      check("rst_ctrl", 64'({pix_ready, en_ref, en_search, we_ref, we_search, busy_ref,
                             busy_search, go, frame_done, underflow_err}), 64'(0));
      check("rst_data", 64'({addr_ref, addr_search, din_ref, din_search}), 64'(0));
      m_active = 0; m_go = 0; m_fd = 0; m_uf = 0; m_beats = 0; m_res = 0;
      q.delete();
    end else begin
      rdy = exp_ready();
      check("pix_ready", 64'(pix_ready), 64'(rdy));
      check("go", 64'(go), 64'(m_go));
      check("frame_done", 64'(frame_done), 64'(m_fd));
      check("underflow_err", 64'(underflow_err), 64'(m_uf));
      acc      = pix_valid && rdy;
      done_row = acc && ((m_beats % H) == H - 1);
      fin_ok   = finished_row && (m_res > 0);
      if (acc) begin
        e.cyc  = cyc + 1;
        e.addr = AW'(((m_beats / H) % N) * H + (m_beats % H));
        e.r    = pix_ref;
        e.s    = pix_search;
        q.push_back(e);
      end
      if (finished_row && m_res == 0) m_uf = 1;
      m_fd = 0;
      if (m_active) begin
        rows_pre = m_beats / H;
        if (m_res == GO_ROWS) m_go = 1;
        m_res   = m_res + int'(done_row) - int'(fin_ok);
        m_beats = m_beats + int'(acc);
        if (rows_pre == V && m_res == 0) begin
          m_fd = 1; m_active = 0; m_go = 0; m_frames++;
        end
      end else if (start) begin
        m_active = 1; m_beats = 0; m_res = 0; m_go = 0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    bit exp_wr;
    wr_t e;
    if (reset) begin
      exp_wr = (q.size() > 0) && (q[0].cyc == cyc);
      check("wr_strobe", 64'({en_ref, we_ref, busy_ref, en_search, we_search, busy_search}),
            64'({6{exp_wr}}));
      if (we_ref != '0) wr_count++;
      if (exp_wr) begin
        e = q.pop_front();
        check("addr_ref", 64'(addr_ref), 64'(e.addr));
        check("addr_search", 64'(addr_search), 64'(e.addr));
        check("din_ref", 64'(din_ref), 64'(e.r));
        check("din_search", 64'(din_search), 64'(e.s));
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        check("wr_missed_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: random; 1: continuous stream, consume only when ring full; 2: consume on row ends
  task automatic drive(input int mode);
    bit drain;
    drain      = (m_beats / H == V) && (m_res > 0);
    pix_ref    = DW'($urandom);
    pix_search = DW'($urandom);
    start      = 1'b0;
    case (mode)
      1: begin
        pix_valid    = 1'b1;
        pix_ref      = DW'((m_beats % H) % 10);
        finished_row = (m_res == N) || drain;
      end
      2: begin
        pix_valid    = 1'b1;
        finished_row = (m_res > 0) &&
                       ((m_res == N) || drain || (exp_ready() && (m_beats % H) == H - 1));
      end
      default: begin
        pix_valid    = ($urandom_range(0, 9) < 7);
        finished_row = (m_res > 0) && ($urandom_range(0, 3) == 0);
        start        = m_active && ($urandom_range(0, 19) == 0);
      end
    endcase
  endtask

  task automatic run_frame(input int mode, input int budget, input string name);
    int f0, w0;
    f0 = m_frames;
    w0 = wr_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < budget && m_frames == f0; i++) begin
      drive(mode);
      tick();
    end
    pix_valid = 1'b0; finished_row = 1'b0; start = 1'b0;
    check({name, "_done"}, 64'(m_frames), 64'(f0 + 1));
    check({name, "_writes"}, 64'(wr_count - w0), 64'(H * V));
    repeat (3) tick();
  endtask

  initial begin
    int w0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();

    finished_row = 1'b1;
    tick();
    finished_row = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (2) tick();

    run_frame(1, 3000, "fill");
    run_frame(2, 3000, "coincident");
    run_frame(0, 4000, "random_a");
    run_frame(0, 4000, "random_b");

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      drive(0);
      tick();
    end
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    w0 = wr_count;
    pix_valid = 1'b1; finished_row = 1'b0; start = 1'b0;
    repeat (20) tick();
    pix_valid = 1'b0;
    check("no_write_without_start", 64'(wr_count - w0), 64'(0));
    tick();

    run_frame(0, 4000, "after_reset");

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
